// File: rtl/clock_state_keeper_if.sv
// Signal bundle between the Nixie clock front end / display path and the
// timekeeping core. The core sits on the slave side; the front end (or a
// bench) drives the master side.
interface clock_state_keeper_if;
  // Control from the button/cursor front end
  logic       mode24;
  logic       up;
  logic       down;
  logic       clear;
  logic [4:0] cursorPos;
  logic       alarmEn;

  // Formatted time and alarm towards the digit path
  logic [5:0] second;
  logic [5:0] minute;
  logic [5:0] hour;
  logic       pm;
  logic [5:0] alarmMinute;
  logic [5:0] alarmHour;
  logic       secTick;
  logic       alarmPulse;

  modport master (
    output mode24, up, down, clear, cursorPos, alarmEn,
    input  second, minute, hour, pm, alarmMinute, alarmHour, secTick, alarmPulse
  );

  modport slave (
    input  mode24, up, down, clear, cursorPos, alarmEn,
    output second, minute, hour, pm, alarmMinute, alarmHour, secTick, alarmPulse
  );
endinterface

// File: rtl/clock_state_keeper.sv
// Timekeeping core for the Nixie clock. Keeps hh:mm:ss and an alarm hh:mm,
// advances time once per TICK_DIV clocks, applies single-step adjustments to
// the field picked by a one-hot cursor and presents 12h/24h formatted values.
// Hours are always stored 0..23; the 12h view is derived combinationally so a
// mode24 change shows up without waiting for a clock edge.
module clock_state_keeper #(
  parameter int unsigned TICK_DIV = 100_000_000,
  parameter int unsigned PRE_W    = 27
) (
  input logic                 clk,
  input logic                 reset_n,
  clock_state_keeper_if.slave bus
);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [5:0]       SEC_MAX  = 6'd59;
  localparam logic [5:0]       MIN_MAX  = 6'd59;
  localparam logic [5:0]       HOUR_MAX = 6'd23;

  // Cursor bit positions
  localparam int SEL_SEC       = 0;
  localparam int SEL_MIN       = 1;
  localparam int SEL_HOUR      = 2;
  localparam int SEL_ALARM_MIN = 3;
  localparam int SEL_ALARM_HR  = 4;

  // Step a field by one in either direction, wrapping between 0 and max_v.
  function automatic logic [5:0] step_wrap(input logic [5:0] v,
                                           input logic [5:0] max_v,
                                           input logic       inc);
    if (inc) return (v == max_v) ? 6'd0 : v + 6'd1;
    else     return (v == 6'd0)  ? max_v : v - 6'd1;
  endfunction

  // Present an internal 0..23 hour in the requested display format.
  function automatic logic [5:0] fmt_hour(input logic [5:0] h, input logic as24);
    if (as24)          return h;
    else if (h == 6'd0) return 6'd12;
    else if (h > 6'd12) return h - 6'd12;
    else               return h;
  endfunction

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [5:0]       sec_q, sec_d;
  logic [5:0]       min_q, min_d;
  logic [5:0]       hour_q, hour_d;
  logic [5:0]       alm_min_q, alm_min_d;
  logic [5:0]       alm_hour_q, alm_hour_d;
  logic             sec_tick_q, alarm_pulse_q;

  logic cursor_onehot;
  logic adj_valid;
  logic adj_time;
  logic tick;
  logic tick_taken;
  logic alarm_hit;

  // Decode which request wins this cycle.
  assign cursor_onehot = (bus.cursorPos != 5'd0) &&
                         ((bus.cursorPos & (bus.cursorPos - 5'd1)) == 5'd0);
  assign adj_valid     = (bus.up ^ bus.down) && cursor_onehot && !bus.clear;
  assign adj_time      = adj_valid && (bus.cursorPos[2:0] != 3'b000);
  assign tick          = (pre_q == PRE_LAST);

  // Next-state for prescaler, time and alarm with priority clear > adjust > tick.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave
    // it unassigned and infer a latch.
    pre_d      = tick ? '0 : pre_q + 1'b1;
    sec_d      = sec_q;
    min_d      = min_q;
    hour_d     = hour_q;
    alm_min_d  = alm_min_q;
    alm_hour_d = alm_hour_q;
    tick_taken = 1'b0;

    if (bus.clear) begin
      pre_d  = '0;
      sec_d  = 6'd0;
      min_d  = 6'd0;
      hour_d = 6'd0;
    end else begin
      if (adj_valid) begin
        if (bus.cursorPos[SEL_SEC])       sec_d      = step_wrap(sec_q,      SEC_MAX,  bus.up);
        if (bus.cursorPos[SEL_MIN])       min_d      = step_wrap(min_q,      MIN_MAX,  bus.up);
        if (bus.cursorPos[SEL_HOUR])      hour_d     = step_wrap(hour_q,     HOUR_MAX, bus.up);
        if (bus.cursorPos[SEL_ALARM_MIN]) alm_min_d  = step_wrap(alm_min_q,  MIN_MAX,  bus.up);
        if (bus.cursorPos[SEL_ALARM_HR])  alm_hour_d = step_wrap(alm_hour_q, HOUR_MAX, bus.up);
      end

      // A time-field edit restarts the second and swallows a coincident tick;
      // alarm edits leave real time running.
      if (adj_time) begin
        pre_d = '0;
      end else if (tick) begin
        tick_taken = 1'b1;
        sec_d      = step_wrap(sec_q, SEC_MAX, 1'b1);
        if (sec_q == SEC_MAX) begin
          min_d = step_wrap(min_q, MIN_MAX, 1'b1);
          if (min_q == MIN_MAX) hour_d = step_wrap(hour_q, HOUR_MAX, 1'b1);
        end
      end
    end
  end

  // Only a real-time advance can trigger the alarm, never an edit or clear.
  assign alarm_hit = tick_taken && bus.alarmEn && (sec_d == 6'd0) &&
                     (min_d == alm_min_q) && (hour_d == alm_hour_q);

  // State and pulse registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_q         <= '0;
      sec_q         <= 6'd0;
      min_q         <= 6'd0;
      hour_q        <= 6'd0;
      alm_min_q     <= 6'd0;
      alm_hour_q    <= 6'd0;
      sec_tick_q    <= 1'b0;
      alarm_pulse_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      pre_q         <= pre_d;
      sec_q         <= sec_d;
      min_q         <= min_d;
      hour_q        <= hour_d;
      alm_min_q     <= alm_min_d;
      alm_hour_q    <= alm_hour_d;
      sec_tick_q    <= tick_taken;
      alarm_pulse_q <= alarm_hit;
    end
  end

  assign bus.second      = sec_q;
  assign bus.minute      = min_q;
  assign bus.hour        = fmt_hour(hour_q, bus.mode24);
  assign bus.pm          = (hour_q >= 6'd12);
  assign bus.alarmMinute = alm_min_q;
  assign bus.alarmHour   = fmt_hour(alm_hour_q, bus.mode24);
  assign bus.secTick     = sec_tick_q;
  assign bus.alarmPulse  = alarm_pulse_q;

endmodule
